// File: rtl/rvjtag_dmi_ctrl.sv
// DMI transaction sequencer between the JTAG TAP DMI register and the debug module bus (tck domain).
// Optional per-transaction abort timer: define RVJTAG_DMI_TIMEOUT_EN.
module rvjtag_dmi_ctrl #(
    parameter int         AWIDTH         = 7,
    parameter logic [2:0] IDLE_HINT      = 3'd1,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              tap_wr_en,
    input  logic              tap_rd_en,
    input  logic [AWIDTH-1:0] tap_addr,
    input  logic [31:0]       tap_wdata,
    output logic [31:0]       tap_rd_data,
    output logic [1:0]        tap_rd_status,
    output logic [1:0]        dmi_stat,
    output logic [2:0]        idle,
    input  logic              dmi_reset,
    input  logic              dmi_hard_reset,
    output logic              dmi_req_valid,
    output logic              dmi_req_write,
    output logic [AWIDTH-1:0] dmi_req_addr,
    output logic [31:0]       dmi_req_wdata,
    input  logic              dmi_req_ready,
    input  logic              dmi_rsp_valid,
    input  logic [31:0]       dmi_rsp_data,
    input  logic              dmi_rsp_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [1:0] sticky, sticky_next;
    logic       sticky_set;
    logic       latch_op;
    logic       load_rd;
    logic       op_any;
    logic       op_one;

    assign op_any = tap_wr_en | tap_rd_en;
    assign op_one = tap_wr_en ^ tap_rd_en;

`ifdef RVJTAG_DMI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge tck or negedge trst) begin
        if (!trst)
            tmo_cnt <= '0;
        else if (latch_op)
            tmo_cnt <= '0;
        else if (state != IDLE)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    always_comb begin
        state_next  = state;
        sticky_next = sticky;
        sticky_set  = 1'b0;
        latch_op    = 1'b0;
        load_rd     = 1'b0;

        // Overlapping op: dropped, flagged busy only if no error is pending.
        if (state != IDLE && op_any && sticky == 2'd0) begin
            sticky_next = 2'd3;
            sticky_set  = 1'b1;
        end

        case (state)
            IDLE: begin
                if (op_any && sticky == 2'd0) begin
                    if (op_one) begin
                        latch_op   = 1'b1;
                        state_next = REQ;
                    end else begin
                        sticky_next = 2'd2;
                        sticky_set  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmi_req_ready)
                    state_next = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (dmi_rsp_valid) begin
                    state_next = IDLE;
                    if (dmi_rsp_err) begin
                        sticky_next = 2'd2;
                        sticky_set  = 1'b1;
                    end else if (!dmi_req_write) begin
                        load_rd = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef RVJTAG_DMI_TIMEOUT_EN
        // A response landing on the expiry cycle completes normally.
        if (tmo_hit && !(state == WAIT_RSP && dmi_rsp_valid)) begin
            state_next  = IDLE;
            sticky_next = 2'd2;
            sticky_set  = 1'b1;
        end
`endif

        if (dmi_reset && !sticky_set)
            sticky_next = 2'd0;

        if (dmi_hard_reset) begin
            state_next  = IDLE;
            sticky_next = 2'd0;
            latch_op    = 1'b0;
            load_rd     = 1'b0;
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state         <= IDLE;
            sticky        <= 2'd0;
            dmi_req_valid <= 1'b0;
            dmi_req_write <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_wdata <= '0;
            tap_rd_data   <= '0;
        end else begin
            state         <= state_next;
            sticky        <= sticky_next;
            dmi_req_valid <= (state_next == REQ);
            if (latch_op) begin
                dmi_req_write <= tap_wr_en;
                dmi_req_addr  <= tap_addr;
                dmi_req_wdata <= tap_wdata;
            end
            if (load_rd)
                tap_rd_data <= dmi_rsp_data;
        end
    end

    assign tap_rd_status = (sticky != 2'd0) ? sticky : ((state != IDLE) ? 2'd3 : 2'd0);
    assign dmi_stat      = sticky;
    assign idle          = IDLE_HINT;

endmodule

// File: tb/tb_rvjtag_dmi_ctrl.sv
// Self-checking bench for rvjtag_dmi_ctrl: directed scenarios plus a randomized
// transaction mix checked against a transaction-level model of status and read data.
module tb_rvjtag_dmi_ctrl;

    logic        tck = 1'b0;
    logic        trst;
    logic        tap_wr_en, tap_rd_en;
    logic [6:0]  tap_addr;
    logic [31:0] tap_wdata;
    logic [31:0] tap_rd_data;
    logic [1:0]  tap_rd_status;
    logic [1:0]  dmi_stat;
    logic [2:0]  idle;
    logic        dmi_reset, dmi_hard_reset;
    logic        dmi_req_valid, dmi_req_write;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_wdata;
    logic        dmi_req_ready;
    logic        dmi_rsp_valid;
    logic [31:0] dmi_rsp_data;
    logic        dmi_rsp_err;

    int checks = 0;
    int passed = 0;

    // Model: sticky status and the read data the TAP should see.
    logic [1:0]  m_sticky;
    logic [31:0] m_rd;

    rvjtag_dmi_ctrl #(.AWIDTH(7), .IDLE_HINT(3'd1), .TIMEOUT_CYCLES(8)) dut (
        .tck(tck), .trst(trst),
        .tap_wr_en(tap_wr_en), .tap_rd_en(tap_rd_en),
        .tap_addr(tap_addr), .tap_wdata(tap_wdata),
        .tap_rd_data(tap_rd_data), .tap_rd_status(tap_rd_status),
        .dmi_stat(dmi_stat), .idle(idle),
        .dmi_reset(dmi_reset), .dmi_hard_reset(dmi_hard_reset),
        .dmi_req_valid(dmi_req_valid), .dmi_req_write(dmi_req_write),
        .dmi_req_addr(dmi_req_addr), .dmi_req_wdata(dmi_req_wdata),
        .dmi_req_ready(dmi_req_ready),
        .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data),
        .dmi_rsp_err(dmi_rsp_err)
    );

    always #5 tck = ~tck;

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    // One TAP op; ready on the (rdy_dly+1)-th valid cycle, response rsp_dly cycles after ready.
    task automatic run_op(input bit w, input logic [6:0] a, input logic [31:0] d,
                          input int rdy_dly, input int rsp_dly, input bit err,
                          input logic [31:0] rdata, input string nm);
        tap_wr_en = w;
        tap_rd_en = !w;
        tap_addr  = a;
        tap_wdata = d;
        step();
        tap_wr_en = 1'b0;
        tap_rd_en = 1'b0;
        tap_addr  = 7'($urandom);
        tap_wdata = $urandom;
        if (m_sticky != 2'd0) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dmi_req_valid !== 1'b0 || tap_rd_status !== m_sticky)
                    $display("FAIL %s_ignored valid=%0b status=%0d want valid=0 status=%0d",
                             nm, dmi_req_valid, tap_rd_status, m_sticky);
                else passed++;
                step();
            end
            return;
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            checks++;
            if ({dmi_req_valid, dmi_req_write, dmi_req_addr, dmi_req_wdata, tap_rd_status} !==
                {1'b1, w, a, d, 2'd3})
                $display("FAIL %s_req cyc%0d got v=%0b w=%0b a=%h d=%h st=%0d want v=1 w=%0b a=%h d=%h st=3",
                         nm, k, dmi_req_valid, dmi_req_write, dmi_req_addr, dmi_req_wdata,
                         tap_rd_status, w, a, d);
            else passed++;
            dmi_req_ready = (k == rdy_dly);
            step();
        end
        dmi_req_ready = 1'b0;
        checks++;
        if (dmi_req_valid !== 1'b0 || tap_rd_status !== 2'd3)
            $display("FAIL %s_wait got valid=%0b status=%0d want valid=0 status=3",
                     nm, dmi_req_valid, tap_rd_status);
        else passed++;
        repeat (rsp_dly - 1) step();
        dmi_rsp_valid = 1'b1;
        dmi_rsp_data  = rdata;
        dmi_rsp_err   = err;
        step();
        dmi_rsp_valid = 1'b0;
        dmi_rsp_err   = 1'b0;
        dmi_rsp_data  = '0;
        if (err) m_sticky = 2'd2;
        else if (!w) m_rd = rdata;
        checks++;
        if ({tap_rd_data, dmi_stat, tap_rd_status, dmi_req_valid} !== {m_rd, m_sticky, m_sticky, 1'b0})
            $display("FAIL %s_done got rd=%h stat=%0d st=%0d v=%0b want rd=%h stat=%0d st=%0d v=0",
                     nm, tap_rd_data, dmi_stat, tap_rd_status, dmi_req_valid, m_rd, m_sticky, m_sticky);
        else passed++;
    endtask

    task automatic do_dmi_reset(input string nm);
        dmi_reset = 1'b1;
        step();
        dmi_reset = 1'b0;
        m_sticky = 2'd0;
        checks++;
        if (dmi_stat !== 2'd0 || tap_rd_status !== 2'd0)
            $display("FAIL %s got stat=%0d status=%0d want 0/0", nm, dmi_stat, tap_rd_status);
        else passed++;
    endtask

    task automatic do_reserved(input bit with_reset, input string nm);
        tap_wr_en = 1'b1;
        tap_rd_en = 1'b1;
        dmi_reset = with_reset;
        step();
        tap_wr_en = 1'b0;
        tap_rd_en = 1'b0;
        dmi_reset = 1'b0;
        if (m_sticky == 2'd0) m_sticky = 2'd2;
        else if (with_reset) m_sticky = 2'd0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dmi_req_valid !== 1'b0 || dmi_stat !== m_sticky || tap_rd_status !== m_sticky)
                $display("FAIL %s got v=%0b stat=%0d st=%0d want v=0 stat=%0d st=%0d",
                         nm, dmi_req_valid, dmi_stat, tap_rd_status, m_sticky, m_sticky);
            else passed++;
            step();
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({dmi_req_valid, dmi_req_write, dmi_req_addr, dmi_req_wdata, tap_rd_data,
             tap_rd_status, dmi_stat, idle} !== {1'b0, 1'b0, 7'h0, 32'h0, 32'h0, 2'd0, 2'd0, 3'd1})
            $display("FAIL reset got v=%0b rd=%h st=%0d stat=%0d idle=%0d want 0,0,0,0,idle=1",
                     dmi_req_valid, tap_rd_data, tap_rd_status, dmi_stat, idle);
        else passed++;
        step();
        step();
        trst = 1'b1;
        m_sticky = 2'd0;
        m_rd = '0;
        step();
    endtask

    task automatic test_read();
        run_op(1'b0, 7'h11, 32'h0, 2, 3, 1'b0, 32'hDEADBEEF, "read");
    endtask

    task automatic test_write();
        run_op(1'b1, 7'h10, 32'h00000001, 0, 2, 1'b0, 32'h12345678, "write");
    endtask

    task automatic test_busy_overlap();
        tap_rd_en = 1'b1;
        tap_addr  = 7'h05;
        step();
        tap_rd_en = 1'b0;
        dmi_req_ready = 1'b1;
        step();
        dmi_req_ready = 1'b0;
        tap_rd_en = 1'b1;
        tap_addr  = 7'h06;
        step();
        tap_rd_en = 1'b0;
        checks++;
        if (dmi_req_valid !== 1'b0 || dmi_stat !== 2'd3 || tap_rd_status !== 2'd3)
            $display("FAIL busy_flag got v=%0b stat=%0d st=%0d want v=0 stat=3 st=3",
                     dmi_req_valid, dmi_stat, tap_rd_status);
        else passed++;
        step();
        checks++;
        if (dmi_req_valid !== 1'b0)
            $display("FAIL busy_no_second_req got valid=%0b want 0", dmi_req_valid);
        else passed++;
        dmi_rsp_valid = 1'b1;
        dmi_rsp_data  = 32'hCAFE0005;
        step();
        dmi_rsp_valid = 1'b0;
        dmi_rsp_data  = '0;
        m_rd = 32'hCAFE0005;
        m_sticky = 2'd3;
        checks++;
        if ({tap_rd_data, dmi_stat, tap_rd_status} !== {m_rd, 2'd3, 2'd3})
            $display("FAIL busy_after_rsp got rd=%h stat=%0d st=%0d want rd=%h stat=3 st=3",
                     tap_rd_data, dmi_stat, tap_rd_status, m_rd);
        else passed++;
        run_op(1'b0, 7'h07, 32'h0, 1, 1, 1'b0, $urandom, "busy_ignored");
        do_dmi_reset("busy_dmireset");
        run_op(1'b0, 7'h08, 32'h0, 0, 1, 1'b0, 32'h0BADF00D, "busy_next_op");
    endtask

    task automatic test_error();
        run_op(1'b0, 7'h12, 32'h0, 1, 2, 1'b1, 32'h55555555, "rd_err");
        do_dmi_reset("err_dmireset");
        do_reserved(1'b0, "reserved");
        do_dmi_reset("rsv_dmireset");
        do_reserved(1'b1, "reserved_vs_reset");
        do_dmi_reset("rsv2_dmireset");
    endtask

    task automatic test_hard_reset();
        tap_rd_en = 1'b1;
        tap_addr  = 7'h22;
        step();
        tap_rd_en = 1'b0;
        step();
        tap_rd_en = 1'b1;
        step();
        tap_rd_en = 1'b0;
        checks++;
        if (dmi_req_valid !== 1'b1 || dmi_stat !== 2'd3 || tap_rd_status !== 2'd3)
            $display("FAIL hard_pre got v=%0b stat=%0d st=%0d want v=1 stat=3 st=3",
                     dmi_req_valid, dmi_stat, tap_rd_status);
        else passed++;
        dmi_hard_reset = 1'b1;
        step();
        dmi_hard_reset = 1'b0;
        m_sticky = 2'd0;
        checks++;
        if ({dmi_req_valid, dmi_stat, tap_rd_status, tap_rd_data} !== {1'b0, 2'd0, 2'd0, m_rd})
            $display("FAIL hard_abort got v=%0b stat=%0d st=%0d rd=%h want 0,0,0,rd=%h",
                     dmi_req_valid, dmi_stat, tap_rd_status, tap_rd_data, m_rd);
        else passed++;
        step();
        dmi_rsp_valid = 1'b1;
        dmi_rsp_data  = $urandom;
        dmi_rsp_err   = 1'b1;
        step();
        dmi_rsp_valid = 1'b0;
        dmi_rsp_err   = 1'b0;
        checks++;
        if ({dmi_req_valid, dmi_stat, tap_rd_status, tap_rd_data} !== {1'b0, 2'd0, 2'd0, m_rd})
            $display("FAIL hard_late_rsp got v=%0b stat=%0d st=%0d rd=%h want 0,0,0,rd=%h",
                     dmi_req_valid, dmi_stat, tap_rd_status, tap_rd_data, m_rd);
        else passed++;
        run_op(1'b1, 7'h23, 32'hA5A5A5A5, 1, 1, 1'b0, 32'h0, "hard_next_op");
    endtask

`ifdef RVJTAG_DMI_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        tap_rd_en = 1'b1;
        tap_addr  = 7'h30;
        step();
        tap_rd_en = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (tap_rd_status !== 2'd3) break;
            n++;
            step();
        end
        m_sticky = 2'd2;
        checks++;
        if (n != 8 || dmi_stat !== 2'd2 || dmi_req_valid !== 1'b0)
            $display("FAIL timeout got busy_cycles=%0d stat=%0d v=%0b want 8 stat=2 v=0",
                     n, dmi_stat, dmi_req_valid);
        else passed++;
        dmi_rsp_valid = 1'b1;
        dmi_rsp_data  = $urandom;
        step();
        dmi_rsp_valid = 1'b0;
        checks++;
        if (tap_rd_data !== m_rd || dmi_stat !== 2'd2)
            $display("FAIL timeout_late_rsp got rd=%h stat=%0d want rd=%h stat=2",
                     tap_rd_data, dmi_stat, m_rd);
        else passed++;
        do_dmi_reset("timeout_dmireset");
    endtask
`endif

    task automatic test_trst_mid_op();
        tap_wr_en = 1'b1;
        tap_addr  = 7'h3C;
        tap_wdata = 32'hFFFF0000;
        step();
        tap_wr_en = 1'b0;
        step();
        checks++;
        if (dmi_req_valid !== 1'b1 || tap_rd_data === 32'h0)
            $display("FAIL trst_pre got v=%0b rd=%h want v=1 rd nonzero", dmi_req_valid, tap_rd_data);
        else passed++;
        trst = 1'b0;
        #1;
        checks++;
        if ({dmi_req_valid, dmi_req_write, dmi_req_addr, dmi_req_wdata, tap_rd_data,
             tap_rd_status, dmi_stat, idle} !== {1'b0, 1'b0, 7'h0, 32'h0, 32'h0, 2'd0, 2'd0, 3'd1})
            $display("FAIL trst_async got v=%0b w=%0b a=%h d=%h rd=%h st=%0d stat=%0d idle=%0d want reset values",
                     dmi_req_valid, dmi_req_write, dmi_req_addr, dmi_req_wdata, tap_rd_data,
                     tap_rd_status, dmi_stat, idle);
        else passed++;
        step();
        trst = 1'b1;
        m_sticky = 2'd0;
        m_rd = '0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 11);
            if (sel < 8)
                run_op(1'($urandom_range(0, 1)), 7'($urandom), $urandom,
                       $urandom_range(0, 3), $urandom_range(1, 4),
                       ($urandom_range(0, 7) == 0), $urandom, "rand_op");
            else if (sel < 10)
                do_dmi_reset("rand_dmireset");
            else
                do_reserved(1'($urandom_range(0, 1)), "rand_reserved");
        end
    endtask

    initial begin
        trst = 1'b0;
        tap_wr_en = 1'b0;
        tap_rd_en = 1'b0;
        tap_addr = '0;
        tap_wdata = '0;
        dmi_reset = 1'b0;
        dmi_hard_reset = 1'b0;
        dmi_req_ready = 1'b0;
        dmi_rsp_valid = 1'b0;
        dmi_rsp_data = '0;
        dmi_rsp_err = 1'b0;
        m_sticky = 2'd0;
        m_rd = '0;
        test_reset();
        test_read();
        test_write();
        test_busy_overlap();
        test_error();
        test_hard_reset();
`ifdef RVJTAG_DMI_TIMEOUT_EN
        test_timeout();
`endif
        test_trst_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
